linx_uart_loader: RTL
=====================

Name: linx_uart_loader

Overview:
UART-driven boot loader and run controller for the Zybo bring-up top. It parses framed byte commands from a UART receiver into 64-bit host write bursts on the core's host_w* port. It also drives the core hold, which is OR-ed into the core reset, so programs load and start without re-synthesising the memory image. Each completed command returns a one-byte ack that the top feeds into the existing UART TX FIFO.

Parameters:
TIMEOUT_CYCLES, 12_500_000, idle cycles between bytes of one frame before it is aborted (100 ms at 125 MHz)
HOLD_ON_RESET, 1, core_hold value after rst (1 = core held until RUN)

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
host_wvalid  out  1  one-cycle host write strobe
host_waddr  out  64  8-byte-aligned write address
host_wdata  out  64  write data, byte lane i = bits [8i+7:8i]
host_wstrb  out  8  byte enables
core_hold  out  1  1 = core held in reset
busy  out  1  frame in progress (state != IDLE)
err  out  1  sticky error flag
ack_valid  out  1  one-cycle ack strobe
ack_data  out  8  0x4B 'K' = ok, 0x45 'E' = error

Behaviour:
- Reset values: all outputs 0, except core_hold = HOLD_ON_RESET. FSM returns to IDLE; accumulator, strobe and checksum are cleared.
- Frame format: SYNC 0xA5, then CMD. Commands:
  - 0x01 WRITE: ADDR 4 bytes LE, then LEN 2 bytes LE, then LEN data bytes, then [CKSUM].
  - 0x02 RUN.
  - 0x03 HALT.
- FSM states and transitions:
  - IDLE: byte 0xA5 -> CMD. Any other byte is ignored.
  - CMD:
    - 0x01 with core_hold=1 -> ADDR.
    - 0x01 with core_hold=0 -> IDLE, ack 'E', err set.
    - 0x02 -> IDLE, core_hold<=0, ack 'K'.
    - 0x03 -> IDLE, core_hold<=1, ack 'K'.
    - Any other value -> IDLE, ack 'E', err set.
  - ADDR: collects 4 bytes; address is zero-extended to 64 bits. Then -> LEN.
  - LEN: collects 2 bytes. LEN=0 -> CKSUM if enabled, otherwise IDLE with ack 'K' and no write. LEN>0 -> DATA.
  - DATA:
    - Each byte goes to lane addr[2:0] and sets strb[addr[2:0]]; addr increments by 1, wrapping modulo 2^32.
    - Flush when lane==7 or the byte is the last of LEN. On flush: next cycle host_wvalid=1 with waddr={addr[63:3],3'b000} of the flushed word, plus wdata and wstrb. Lanes not enabled in wstrb carry 0. The accumulator clears in the same cycle.
    - After the last byte -> CKSUM if enabled, otherwise IDLE with ack 'K'. The ack is issued in the same cycle as the final host_wvalid.
- host_wvalid is never asserted on two consecutive cycles unless two rx_valid strobes are consecutive. The interface has no backpressure.
- Timeout:
  - Counter clears on every rx_valid and counts only while state != IDLE.
  - At TIMEOUT_CYCLES: the partial word is discarded (no write), FSM -> IDLE, ack 'E', err set.
  - Words already written stay written.
- rx_valid arriving in the same cycle as the timeout is taken as the timeout; the byte is dropped.
- err is cleared only by rst. err does not block RUN unless the checksum feature is present.
- rst mid-frame: immediate IDLE, no host_wvalid or ack on the following cycle, core_hold = HOLD_ON_RESET.

Optional Feature:
LINX_LOADER_CKSUM_EN
- Defined: WRITE carries a trailing CKSUM byte equal to the XOR of all data bytes (0x00 when LEN=0).
  - Match: ack 'K'.
  - Mismatch: ack 'E', err set; writes already issued stand.
  - RUN while err=1 is refused: ack 'E', core_hold stays 1.
- Undefined: no CKSUM state. A WRITE ends after the last data byte and RUN ignores err.

Decomposition:
- Package linx_loader_pkg holds:
  - state enum {IDLE, CMD, ADDR, LEN, DATA, CKSUM};
  - localparams SYNC_BYTE=8'hA5, CMD_WRITE=8'h01, CMD_RUN=8'h02, CMD_HALT=8'h03, ACK_OK=8'h4B, ACK_ERR=8'h45.
- Sub-module linx_loader_wordpack: byte-lane accumulator with lane, data, strobe, flush and clear. It owns host_wdata, host_wstrb and host_wvalid registration.

Test Plan:
- Reset then frame A5 01 00 00 01 00 08 00 11 22 33 44 55 66 77 88 -> one host_wvalid, waddr=0x10000, wdata=0x8877665544332211, wstrb=0xFF; ack 'K'; core_hold=1 throughout.
- Unaligned WRITE, addr 0x10005, LEN=4, data AA BB CC DD -> two writes:
  - waddr 0x10000, wstrb 0xE0, lanes 5-7 = AA BB CC;
  - waddr 0x10008, wstrb 0x01, lane 0 = DD;
  - then ack 'K'.
- A5 02 -> core_hold 0 next cycle, ack 'K'. Then A5 01 -> ack 'E', err=1, no writes. Then A5 03 -> core_hold=1.
- WRITE LEN=8 stalled after 3 data bytes for TIMEOUT_CYCLES (set to 50 in sim) -> no host_wvalid, ack 'E', busy=0. The next valid frame is accepted normally.
- With LINX_LOADER_CKSUM_EN, WRITE LEN=2 data 0F F0 and CKSUM 0x00:
  - checksum mismatch (expected 0xFF) -> ack 'E', err=1;
  - following RUN -> ack 'E', core_hold stays 1.
- Garbage 00 FF 5A, then A5 07 -> garbage ignored, ack 'E' only for the bad CMD; rst mid-DATA -> no further host_wvalid.

Source files
------------

// File: rtl/linx_loader_pkg.sv
// Shared FSM state encoding and protocol byte values for the UART boot loader.
package linx_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        LEN   = 3'd3,
        DATA  = 3'd4,
        CKSUM = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_HALT  = 8'h03;
    localparam logic [7:0] ACK_OK    = 8'h4B;
    localparam logic [7:0] ACK_ERR   = 8'h45;

endpackage

// File: rtl/linx_loader_wordpack.sv
// Byte-lane accumulator: gathers bytes into a 64-bit word and emits it with strobes on flush.
// Output write appears one cycle after the flushing byte; no backpressure, clear discards a partial word.
module linx_loader_wordpack
    import linx_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_byte_vld,
    input  logic [2:0]  i_lane,
    input  logic [7:0]  i_byte,
    input  logic        i_flush,
    input  logic        i_clear,
    output logic        o_wvalid,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wstrb
);

    logic [63:0] r_acc;
    logic [7:0]  r_strb;
    logic        r_wvalid;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [63:0] w_acc_nxt;
    logic [7:0]  w_strb_nxt;

    always_comb begin
        w_acc_nxt  = r_acc;
        w_strb_nxt = r_strb;
        if (i_byte_vld) begin
            w_acc_nxt[{i_lane, 3'b000} +: 8] = i_byte;
            w_strb_nxt[i_lane]               = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_strb   <= '0;
            r_wvalid <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            r_wvalid <= 1'b0;
            if (i_clear) begin
                r_acc  <= '0;
                r_strb <= '0;
            end else if (i_byte_vld && i_flush) begin
                // Unwritten lanes stay zero because the accumulator restarts empty.
                r_wvalid <= 1'b1;
                r_wdata  <= w_acc_nxt;
                r_wstrb  <= w_strb_nxt;
                r_acc    <= '0;
                r_strb   <= '0;
            end else begin
                r_acc  <= w_acc_nxt;
                r_strb <= w_strb_nxt;
            end
        end
    end

    assign o_wvalid = r_wvalid;
    assign o_wdata  = r_wdata;
    assign o_wstrb  = r_wstrb;

endmodule

// File: rtl/linx_uart_loader.sv
// UART framed-command boot loader: WRITE bursts to host_w*, RUN/HALT drive core_hold, one ack per command.
// Optional trailing-checksum support is enabled by defining LINX_LOADER_CKSUM_EN.
module linx_uart_loader
    import linx_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 12_500_000,
    parameter bit HOLD_ON_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        host_wvalid,
    output logic [63:0] host_waddr,
    output logic [63:0] host_wdata,
    output logic [7:0]  host_wstrb,
    output logic        core_hold,
    output logic        busy,
    output logic        err,
    output logic        ack_valid,
    output logic [7:0]  ack_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    logic [31:0]   r_addr;
    logic [15:0]   r_len;
    logic [1:0]    r_cnt;
    logic          r_hold;
    logic          r_err;
    logic          r_ack_vld;
    logic [7:0]    r_ack_dat;
    logic [63:0]   r_waddr;
    logic [TW-1:0] r_tmo;
`ifdef LINX_LOADER_CKSUM_EN
    logic [7:0]    r_cksum;
`endif

    logic          w_tmo;
    logic          w_rx;
    logic          w_data_byte;
    logic          w_last;
    logic          w_flush;
    logic [15:0]   w_len_full;

    // A timeout wins over a byte arriving in the same cycle; that byte is dropped.
    assign w_tmo       = (r_state != IDLE) && (r_tmo == TW'(TIMEOUT_CYCLES));
    assign w_rx        = rx_valid && !w_tmo;
    assign w_data_byte = w_rx && (r_state == DATA);
    assign w_last      = (r_len == 16'd1);
    assign w_flush     = (r_addr[2:0] == 3'd7) || w_last;
    assign w_len_full  = {rx_data, r_len[15:8]};

    linx_loader_wordpack u_pack (
        .clk        (clk),
        .rst        (rst),
        .i_byte_vld (w_data_byte),
        .i_lane     (r_addr[2:0]),
        .i_byte     (rx_data),
        .i_flush    (w_flush),
        .i_clear    (w_tmo),
        .o_wvalid   (host_wvalid),
        .o_wdata    (host_wdata),
        .o_wstrb    (host_wstrb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_hold    <= HOLD_ON_RESET;
            r_err     <= 1'b0;
            r_ack_vld <= 1'b0;
            r_ack_dat <= '0;
            r_waddr   <= '0;
            r_tmo     <= '0;
`ifdef LINX_LOADER_CKSUM_EN
            r_cksum   <= '0;
`endif
        end else begin
            r_ack_vld <= 1'b0;
            if (rx_valid || (r_state == IDLE))
                r_tmo <= '0;
            else if (!w_tmo)
                r_tmo <= r_tmo + TW'(1);

            if (w_tmo) begin
                r_state   <= IDLE;
                r_ack_vld <= 1'b1;
                r_ack_dat <= ACK_ERR;
                r_err     <= 1'b1;
            end else if (w_rx) begin
                case (r_state)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE)
                            r_state <= CMD;
                    end
                    CMD: begin
                        r_state <= IDLE;
                        case (rx_data)
                            CMD_WRITE: begin
                                if (r_hold) begin
                                    r_state <= ADDR;
                                    r_cnt   <= '0;
`ifdef LINX_LOADER_CKSUM_EN
                                    r_cksum <= '0;
`endif
                                end else begin
                                    r_ack_vld <= 1'b1;
                                    r_ack_dat <= ACK_ERR;
                                    r_err     <= 1'b1;
                                end
                            end
                            CMD_RUN: begin
                                r_ack_vld <= 1'b1;
`ifdef LINX_LOADER_CKSUM_EN
                                if (r_err) begin
                                    r_ack_dat <= ACK_ERR;
                                end else begin
                                    r_hold    <= 1'b0;
                                    r_ack_dat <= ACK_OK;
                                end
`else
                                r_hold    <= 1'b0;
                                r_ack_dat <= ACK_OK;
`endif
                            end
                            CMD_HALT: begin
                                r_hold    <= 1'b1;
                                r_ack_vld <= 1'b1;
                                r_ack_dat <= ACK_OK;
                            end
                            default: begin
                                r_ack_vld <= 1'b1;
                                r_ack_dat <= ACK_ERR;
                                r_err     <= 1'b1;
                            end
                        endcase
                    end
                    ADDR: begin
                        r_addr <= {rx_data, r_addr[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3)
                            r_state <= LEN;
                    end
                    LEN: begin
                        r_len <= w_len_full;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd1) begin
                            r_cnt <= '0;
                            if (w_len_full != 16'd0) begin
                                r_state <= DATA;
                            end else begin
`ifdef LINX_LOADER_CKSUM_EN
                                r_state   <= CKSUM;
`else
                                r_state   <= IDLE;
                                r_ack_vld <= 1'b1;
                                r_ack_dat <= ACK_OK;
`endif
                            end
                        end
                    end
                    DATA: begin
                        r_addr <= r_addr + 32'd1;
                        r_len  <= r_len - 16'd1;
`ifdef LINX_LOADER_CKSUM_EN
                        r_cksum <= r_cksum ^ rx_data;
`endif
                        if (w_flush)
                            r_waddr <= {32'd0, r_addr[31:3], 3'b000};
                        if (w_last) begin
`ifdef LINX_LOADER_CKSUM_EN
                            r_state   <= CKSUM;
`else
                            r_state   <= IDLE;
                            r_ack_vld <= 1'b1;
                            r_ack_dat <= ACK_OK;
`endif
                        end
                    end
`ifdef LINX_LOADER_CKSUM_EN
                    CKSUM: begin
                        r_state   <= IDLE;
                        r_ack_vld <= 1'b1;
                        if (rx_data == r_cksum) begin
                            r_ack_dat <= ACK_OK;
                        end else begin
                            r_ack_dat <= ACK_ERR;
                            r_err     <= 1'b1;
                        end
                    end
`endif
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign host_waddr = r_waddr;
    assign core_hold  = r_hold;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;
    assign ack_valid  = r_ack_vld;
    assign ack_data   = r_ack_dat;

endmodule
